// File: rtl/i2s_rx_pkg.sv
// Constants shared by the I2S receive and transmit paths.
// Also holds the framing state type used by i2s_rx.
package i2s_rx_pkg;
    localparam int   AUDIO_WIDTH = 16;
    localparam logic LR_LEFT     = 1'b0;

    typedef enum logic {
        UNARMED = 1'b0,
        ARMED   = 1'b1
    } frame_state_t;
endpackage

// File: rtl/i2s_rx_sync2.sv
// Two-flop synchroniser for one asynchronous I2S pin.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples BCLK/LRCLK/DIN in the clk domain
// and emits left/right sample pairs once the stream is framed.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int WIDTH   = AUDIO_WIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i2s_bclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_din,
    output logic [WIDTH-1:0] audio_l,
    output logic [WIDTH-1:0] audio_r,
    output logic             sample_valid,
    output logic             locked,
    output logic             short_err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic             bclk_s, lr_s, din_s;
    logic             bclk_d, lr_d, din_d, rise;
    logic             lr_prev, left_ok;
    logic [CW-1:0]    cnt, cnt_total;
    logic [IW-1:0]    bit_idx;
    logic [WIDTH-1:0] word, word_in, hold_l;
    logic [TW-1:0]    tcnt;
    logic             slot_end, timeout, short_slot, take_left, emit;
    frame_state_t     state, state_next;

    sync2 u_sync_bclk (.clk(clk), .reset(reset), .d(i2s_bclk),  .q(bclk_s));
    sync2 u_sync_lr   (.clk(clk), .reset(reset), .d(i2s_lrclk), .q(lr_s));
    sync2 u_sync_din  (.clk(clk), .reset(reset), .d(i2s_din),   .q(din_s));

    always_ff @(posedge clk) begin
        if (reset) state <= UNARMED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout)                            state_next = UNARMED;
        else if (slot_end && state == UNARMED)  state_next = ARMED;
    end

    // Slot-end decode; the edge carrying the LRCLK change is the LSB of the old slot.
    always_comb begin
        slot_end   = rise && (lr_d != lr_prev);
        timeout    = !rise && (tcnt == TW'(TIMEOUT));
        cnt_total  = (cnt == CW'(WIDTH)) ? cnt : cnt + CW'(1);
        bit_idx    = IW'(WIDTH - 1 - int'(cnt));
        word_in    = word;
        if (cnt < CW'(WIDTH)) word_in[bit_idx] = din_d;
        short_slot = slot_end && (state == ARMED) && (cnt_total < CW'(WIDTH));
        take_left  = slot_end && (state == ARMED) && !short_slot && (lr_prev == LR_LEFT);
        emit       = slot_end && (state == ARMED) && !short_slot && (lr_prev != LR_LEFT) && left_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_d <= 1'b0;  lr_d <= 1'b0;  din_d <= 1'b0;  rise <= 1'b0;
            lr_prev <= 1'b0; left_ok <= 1'b0;
            cnt <= '0; word <= '0; hold_l <= '0; tcnt <= '0;
            audio_l <= '0; audio_r <= '0;
            sample_valid <= 1'b0; locked <= 1'b0; short_err <= 1'b0;
        end else begin
            // LRCLK/DIN take the same extra stage as BCLK so all three stay aligned
            bclk_d       <= bclk_s;
            lr_d         <= lr_s;
            din_d        <= din_s;
            rise         <= bclk_s & ~bclk_d;
            sample_valid <= emit;
            short_err    <= short_slot;

            if (rise) begin
                tcnt    <= '0;
                lr_prev <= lr_d;
            end else if (tcnt != TW'(TIMEOUT)) begin
                tcnt <= tcnt + TW'(1);
            end

            if (timeout) begin
                locked  <= 1'b0;
                left_ok <= 1'b0;
                cnt     <= '0;
                word    <= '0;
            end else if (slot_end) begin
                cnt  <= '0;
                word <= '0;
                if (short_slot) begin
                    locked  <= 1'b0;
                    left_ok <= 1'b0;
                end
                if (take_left) begin
                    hold_l  <= word_in;
                    left_ok <= 1'b1;
                end
                if (emit) begin
                    audio_l <= hold_l;
                    audio_r <= word_in;
                    locked  <= 1'b1;
                    left_ok <= 1'b0;
                end
            end else if (rise && state == ARMED) begin
                word <= word_in;
                if (cnt != CW'(WIDTH)) cnt <= cnt + CW'(1);
            end
        end
    end
endmodule
